// File: rtl/commit_gather_unit_pkg.sv
// Shared types and sizing for the commit gather path.
// Holds the packet and commit record layouts that the execute side and the
// commit arbiter exchange with commit_gather_unit, plus the warp-to-slot map.
package commit_gather_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned NUM_LANES   = 2;
  localparam int unsigned ISSUE_WIDTH = 2;
  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned UUID_WIDTH  = 8;
  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned NUM_REGS    = 32;

  localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int unsigned PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
  localparam int unsigned NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned ISW_WIDTH   = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam int unsigned RD_WIDTH    = $clog2(NUM_REGS);
  localparam int unsigned TIDX_WIDTH  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  // Lane offset pid*NUM_LANES carries one spare bit above the thread index.
  localparam int unsigned OFF_WIDTH   = $clog2(NUM_THREADS) + 1;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]               uuid;
    logic [NW_WIDTH-1:0]                 wid;
    logic [NUM_LANES-1:0]                tmask;
    logic [PC_WIDTH-1:0]                 pc;
    logic                                wb;
    logic [RD_WIDTH-1:0]                 rd;
    logic [NUM_LANES-1:0][XLEN-1:0]      data;
    logic [PID_WIDTH-1:0]                pid;
    logic                                sop;
    logic                                eop;
  } pkt_data_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]               uuid;
    logic [NW_WIDTH-1:0]                 wid;
    logic [NUM_THREADS-1:0]              tmask;
    logic [PC_WIDTH-1:0]                 pc;
    logic                                wb;
    logic [RD_WIDTH-1:0]                 rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]    data;
  } commit_data_t;

  localparam int unsigned PKT_DATAW    = $bits(pkt_data_t);
  localparam int unsigned COMMIT_DATAW = $bits(commit_data_t);

  function automatic logic [ISW_WIDTH-1:0] wid_to_isw(input logic [NW_WIDTH-1:0] wid);
    int unsigned w;
    w = 32'(wid);
    return ISW_WIDTH'(w % ISSUE_WIDTH);
  endfunction

endpackage

// File: rtl/commit_gather_slot.sv
// One issue slot of the commit gather unit: packet accumulator, IDLE/COLLECT
// FSM and the commit output stage.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   in_valid          packet valid, already filtered for this slot
//   in_data           packet {uuid, wid, tmask, pc, wb, rd, data, pid, sop, eop}
//   in_ready          packet acceptance (valid for any in_data, gated by reset)
//   out_valid/out_data/out_ready  assembled commit record handshake
module commit_gather_slot
  import commit_gather_unit_pkg::*;
#(
  parameter int unsigned OUT_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  pkt_data_t    in_data,
  output logic         in_ready,
  output logic         out_valid,
  output commit_data_t out_data,
  input  logic         out_ready
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                 state, state_n;
  commit_data_t           acc, merged;
  logic                   fire, eop_room;
  logic [OFF_WIDTH-1:0]   lane_off, lane_idx;

  assign fire     = in_valid && in_ready;
  assign in_ready = reset && (!in_data.eop || eop_room);

  // Accumulator merged with the current packet; a sop packet starts from a
  // cleared record so lanes outside its pid never carry stale state.
  always_comb begin
    merged   = acc;
    lane_off = OFF_WIDTH'(in_data.pid) * OFF_WIDTH'(NUM_LANES);
    lane_idx = '0;
    if (in_data.sop || NUM_PACKETS == 1) begin
      merged      = '0;
      merged.uuid = in_data.uuid;
      merged.wid  = in_data.wid;
      merged.pc   = in_data.pc;
      merged.wb   = in_data.wb;
      merged.rd   = in_data.rd;
    end
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      lane_idx = lane_off + OFF_WIDTH'(l);
      merged.tmask[lane_idx[TIDX_WIDTH-1:0]] = in_data.tmask[l];
      merged.data[lane_idx[TIDX_WIDTH-1:0]]  = in_data.data[l];
    end
  end

  always_comb begin
    state_n = state;
    if (fire) begin
      if (in_data.eop) begin
        state_n = IDLE;
      end else if (in_data.sop) begin
        state_n = COLLECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_n;
      if (fire && !in_data.eop) begin
        acc <= merged;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic         ov;
    commit_data_t od;

    // Drain and refill may happen in the same cycle.
    assign eop_room = !ov || out_ready;

    always_ff @(posedge clk) begin
      if (!reset) begin
        ov <= 1'b0;
      end else if (fire && in_data.eop) begin
        ov <= 1'b1;
      end else if (out_ready) begin
        ov <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (fire && in_data.eop) begin
        od <= merged;
      end
    end

    assign out_valid = ov;
    assign out_data  = od;
  end else begin : g_out_comb
    assign eop_room  = out_ready;
    assign out_valid = reset && in_valid && in_data.eop;
    assign out_data  = merged;
  end

  a_sop_in_collect: assert property (@(posedge clk) disable iff (!reset)
    !(fire && in_data.sop && state == COLLECT));
  a_nonsop_in_idle: assert property (@(posedge clk) disable iff (!reset)
    !(fire && !in_data.sop && state == IDLE));
  a_wid_change: assert property (@(posedge clk) disable iff (!reset)
    !(fire && state == COLLECT && in_data.wid != acc.wid));

endmodule

// File: rtl/commit_gather_unit.sv
// Commit gather unit: reassembles NUM_LANES-wide execute result packets into
// NUM_THREADS-wide commit records, one stream per issue slot.
// Block input b serves slots with isw % BLOCK_SIZE == b; slot = wid % ISSUE_WIDTH.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   pkt_in_valid/data/ready       BLOCK_SIZE execute packet streams
//   commit_out_valid/data/ready   ISSUE_WIDTH assembled commit streams
//   perf_stall_cycles, perf_packets  only with COMMIT_GATHER_PERF_EN defined
module commit_gather_unit
  import commit_gather_unit_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 1,
  parameter int unsigned OUT_REG    = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [BLOCK_SIZE-1:0]                    pkt_in_valid,
  input  logic [BLOCK_SIZE-1:0][PKT_DATAW-1:0]     pkt_in_data,
  output logic [BLOCK_SIZE-1:0]                    pkt_in_ready,
  output logic [ISSUE_WIDTH-1:0]                   commit_out_valid,
  output logic [ISSUE_WIDTH-1:0][COMMIT_DATAW-1:0] commit_out_data,
  input  logic [ISSUE_WIDTH-1:0]                   commit_out_ready
`ifdef COMMIT_GATHER_PERF_EN
  ,
  output logic [ISSUE_WIDTH-1:0][31:0]             perf_stall_cycles,
  output logic [31:0]                              perf_packets
`endif
);

  pkt_data_t              pkt     [BLOCK_SIZE];
  logic [ISW_WIDTH-1:0]   pkt_isw [BLOCK_SIZE];
  logic [ISSUE_WIDTH-1:0] slot_valid, slot_ready, ready_sel;

  for (genvar b = 0; b < BLOCK_SIZE; b++) begin : g_in
    logic r;
    assign pkt[b]     = pkt_data_t'(pkt_in_data[b]);
    assign pkt_isw[b] = wid_to_isw(pkt[b].wid);

    always_comb begin
      r = 1'b0;
      for (int unsigned i = b; i < ISSUE_WIDTH; i += BLOCK_SIZE) begin
        r = r | ready_sel[i];
      end
    end
    assign pkt_in_ready[b] = r;
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
    localparam int unsigned B = i % BLOCK_SIZE;
    commit_data_t od;

    assign slot_valid[i] = pkt_in_valid[B] && (pkt_isw[B] == ISW_WIDTH'(i));
    assign ready_sel[i]  = slot_ready[i] && (pkt_isw[B] == ISW_WIDTH'(i));

    commit_gather_slot #(
      .OUT_REG (OUT_REG)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (slot_valid[i]),
      .in_data   (pkt[B]),
      .in_ready  (slot_ready[i]),
      .out_valid (commit_out_valid[i]),
      .out_data  (od),
      .out_ready (commit_out_ready[i])
    );

    assign commit_out_data[i] = od;
  end

`ifdef COMMIT_GATHER_PERF_EN
  logic [31:0] fire_cnt;

  always_comb begin
    fire_cnt = '0;
    for (int unsigned b = 0; b < BLOCK_SIZE; b++) begin
      fire_cnt = fire_cnt + 32'(pkt_in_valid[b] && pkt_in_ready[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_packets      <= '0;
    end else begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
        perf_stall_cycles[i] <= perf_stall_cycles[i]
                                + 32'(commit_out_valid[i] && !commit_out_ready[i]);
      end
      perf_packets <= perf_packets + fire_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_commit_gather_unit.sv
module tb_commit_gather_unit;
  import commit_gather_unit_pkg::*;

  logic                                     clk;
  logic                                     reset;
  logic [0:0]                               pkt_in_valid;
  logic [0:0][PKT_DATAW-1:0]                pkt_in_data;
  logic [0:0]                               pkt_in_ready;
  logic [ISSUE_WIDTH-1:0]                   commit_out_valid;
  logic [ISSUE_WIDTH-1:0][COMMIT_DATAW-1:0] commit_out_data;
  logic [ISSUE_WIDTH-1:0]                   commit_out_ready;
`ifdef COMMIT_GATHER_PERF_EN
  logic [ISSUE_WIDTH-1:0][31:0]             perf_stall_cycles;
  logic [31:0]                              perf_packets;
`endif

  int checks = 0;
  int errors = 0;

  commit_gather_unit #(
    .BLOCK_SIZE (1),
    .OUT_REG    (1)
  ) dut (
`ifdef COMMIT_GATHER_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_packets      (perf_packets),
`endif
    .clk              (clk),
    .reset            (reset),
    .pkt_in_valid     (pkt_in_valid),
    .pkt_in_data      (pkt_in_data),
    .pkt_in_ready     (pkt_in_ready),
    .commit_out_valid (commit_out_valid),
    .commit_out_data  (commit_out_data),
    .commit_out_ready (commit_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld;
    logic [1:0]  wid;
    logic        pid, sop, eop;
    logic [1:0]  tm;
    logic [31:0] d0, d1, pc;
    logic [1:0]  rdy;
    logic        e_rdy;
    logic [1:0]  e_ov;
    logic [3:0]  e_tm;
    logic [31:0] e0, e1, e2, e3, e_pc;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic vld, input logic [1:0] wid, input logic pid,
    input logic sop, input logic eop, input logic [1:0] tm,
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] pc,
    input logic [1:0] rdy, input logic e_rdy, input logic [1:0] e_ov,
    input logic [3:0] e_tm, input logic [31:0] e0, input logic [31:0] e1,
    input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.wid = wid; v.pid = pid; v.sop = sop; v.eop = eop;
    v.tm = tm; v.d0 = d0; v.d1 = d1; v.pc = pc; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_tm = e_tm;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic vec_t idle(input logic rst, input logic [1:0] rdy, input logic e_rdy,
    input logic [1:0] e_ov, input logic [3:0] e_tm, input logic [31:0] e0,
    input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
    input logic [31:0] e_pc);
    return mk(rst, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0, rdy,
              e_rdy, e_ov, e_tm, e0, e1, e2, e3, e_pc);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    pkt_data_t p;
    p       = '0;
    p.uuid  = 8'h5a;
    p.wid   = v.wid;
    p.tmask = v.tm;
    p.pc    = v.pc;
    p.wb    = 1'b1;
    p.rd    = 5'd3;
    p.data[0] = v.d0;
    p.data[1] = v.d1;
    p.pid   = v.pid;
    p.sop   = v.sop;
    p.eop   = v.eop;
    reset            = v.rst;
    pkt_in_valid[0]  = v.vld;
    pkt_in_data[0]   = v.vld ? p : '0;
    commit_out_ready = v.rdy;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    commit_data_t cd;
    int unsigned  s;
    chk({tag, " in_ready"}, 64'(pkt_in_ready[0]), 64'(v.e_rdy));
    chk({tag, " out_valid"}, 64'(commit_out_valid), 64'(v.e_ov));
    if (v.e_ov != 2'b00) begin
      s  = v.e_ov[1] ? 1 : 0;
      cd = commit_data_t'(commit_out_data[s]);
      chk({tag, " tmask"}, 64'(cd.tmask), 64'(v.e_tm));
      chk({tag, " lane0"}, 64'(cd.data[0]), 64'(v.e0));
      chk({tag, " lane1"}, 64'(cd.data[1]), 64'(v.e1));
      chk({tag, " lane2"}, 64'(cd.data[2]), 64'(v.e2));
      chk({tag, " lane3"}, 64'(cd.data[3]), 64'(v.e3));
      chk({tag, " pc"}, 64'(cd.pc), 64'(v.e_pc));
      chk({tag, " uuid"}, 64'(cd.uuid), 64'(8'h5a));
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    apply(v);
    #1;
    check_row(tag, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];

    tv.push_back(idle(0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    // full split, wid 1
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 2'b11, 32'hA, 32'hB, 32'h100, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 1, 0, 1, 2'b11, 32'hC, 32'hD, 32'h999, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(idle(1, 2'b11, 1, 2'b10, 4'b1111, 32'hA, 32'hB, 32'hC, 32'hD, 32'h100));
    // sparse single packet, wid 2 -> slot 0
    tv.push_back(mk(1, 1, 2, 1, 1, 1, 2'b10, 32'h0, 32'h77, 32'h200, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(idle(1, 2'b11, 1, 2'b01, 4'b1000, 0, 0, 0, 32'h77, 32'h200));
    // backpressure on slot 0
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 2'b11, 32'hE, 32'hF, 32'h300, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 1, 0, 1, 2'b01, 32'h10, 32'h0, 32'h0, 2'b10, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 2, 0, 1, 0, 2'b11, 32'h11, 32'h12, 32'h400, 2'b10, 1, 2'b01, 4'b0111, 32'hE, 32'hF, 32'h10, 0, 32'h300));
    tv.push_back(mk(1, 1, 2, 1, 0, 1, 2'b11, 32'h13, 32'h14, 32'h0, 2'b10, 0, 2'b01, 4'b0111, 32'hE, 32'hF, 32'h10, 0, 32'h300));
    tv.push_back(mk(1, 1, 2, 1, 0, 1, 2'b11, 32'h13, 32'h14, 32'h0, 2'b11, 1, 2'b01, 4'b0111, 32'hE, 32'hF, 32'h10, 0, 32'h300));
    tv.push_back(idle(1, 2'b10, 1, 2'b01, 4'b1111, 32'h11, 32'h12, 32'h13, 32'h14, 32'h400));
    tv.push_back(idle(1, 2'b11, 1, 2'b01, 4'b1111, 32'h11, 32'h12, 32'h13, 32'h14, 32'h400));
    // interleaved warps 0 and 1
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 2'b11, 32'h20, 32'h21, 32'h500, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 0, 1, 0, 2'b11, 32'h30, 32'h31, 32'h600, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 1, 0, 1, 2'b11, 32'h22, 32'h23, 32'h0, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 1, 0, 1, 2'b10, 32'h0, 32'h33, 32'h0, 2'b11, 1, 2'b01, 4'b1111, 32'h20, 32'h21, 32'h22, 32'h23, 32'h500));
    tv.push_back(idle(1, 2'b11, 1, 2'b10, 4'b1011, 32'h30, 32'h31, 0, 32'h33, 32'h600));
    // reset mid-collect
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 2'b11, 32'h40, 32'h41, 32'h700, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(idle(0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 2'b01, 32'h50, 32'h0, 32'h800, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 1, 0, 1, 2'b10, 32'h0, 32'h53, 32'h0, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(idle(1, 2'b11, 1, 2'b01, 4'b1001, 32'h50, 0, 0, 32'h53, 32'h800));
    tv.push_back(idle(1, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    // reset while an output is held
    tv.push_back(mk(1, 1, 0, 0, 1, 1, 2'b11, 32'h60, 32'h61, 32'h900, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    tv.push_back(idle(1, 2'b00, 1, 2'b01, 4'b0011, 32'h60, 32'h61, 0, 0, 32'h900));
    tv.push_back(idle(0, 2'b00, 0, 2'b01, 4'b0011, 32'h60, 32'h61, 0, 0, 32'h900));
    tv.push_back(idle(1, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0, 0));

    apply(idle(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      step($sformatf("row%0d", i), tv[i]);
    end

    // Stall/throughput sequence: slot 1 held for three cycles while slot 0
    // keeps draining two single-packet warps.
    step("seq0", idle(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    step("seq1", mk(1, 1, 1, 0, 1, 0, 2'b11, 32'hA, 32'hB, 32'h1000, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    step("seq2", mk(1, 1, 1, 1, 0, 1, 2'b11, 32'hC, 32'hD, 32'h0, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0, 0));
    step("seq3", mk(1, 1, 0, 0, 1, 1, 2'b11, 32'h1, 32'h2, 32'h2000, 2'b01, 1, 2'b10, 4'b1111, 32'hA, 32'hB, 32'hC, 32'hD, 32'h1000));
    step("seq4", mk(1, 1, 0, 0, 1, 1, 2'b11, 32'h3, 32'h4, 32'h3000, 2'b01, 1, 2'b11, 4'b1111, 32'hA, 32'hB, 32'hC, 32'hD, 32'h1000));
    step("seq5", idle(1, 2'b01, 1, 2'b11, 4'b1111, 32'hA, 32'hB, 32'hC, 32'hD, 32'h1000));
    step("seq6", idle(1, 2'b11, 1, 2'b10, 4'b1111, 32'hA, 32'hB, 32'hC, 32'hD, 32'h1000));
    step("seq7", idle(1, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0, 0));
`ifdef COMMIT_GATHER_PERF_EN
    chk("perf_stall1", 64'(perf_stall_cycles[1]), 64'(32'd3));
    chk("perf_stall0", 64'(perf_stall_cycles[0]), 64'(32'd0));
    chk("perf_packets", 64'(perf_packets), 64'(32'd4));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_gather_unit.md
Name: commit_gather_unit

Overview:
- Return-path counterpart of the dispatch splitter. Execute units emit results in NUM_LANES-wide packets tagged with pid/sop/eop; this block reassembles them into full NUM_THREADS-wide commit packets, one stream per issue slot, ahead of the commit/writeback arbiter.
- Block input b feeds only the issue slots whose isw satisfies isw % BLOCK_SIZE == b, so no arbitration is needed.

Parameters:
- BLOCK_SIZE, 1: number of execute-side packet streams; ISSUE_WIDTH must be divisible by it.
- NUM_LANES, 1: lanes per packet; NUM_THREADS must be divisible by it. NUM_PACKETS = NUM_THREADS/NUM_LANES.
- OUT_REG, 1: 1 registers commit_out_* (one full bubble-free stage); 0 makes the assembled output combinational from the eop packet.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- pkt_in_valid  in  BLOCK_SIZE  packet valid.
- pkt_in_data  in  BLOCK_SIZE x PKT_DATAW  {uuid, wid, tmask[NUM_LANES], PC, wb, rd, data[NUM_LANES][XLEN], pid, sop, eop}.
- pkt_in_ready  out  BLOCK_SIZE  packet accepted when valid && ready.
- commit_out_valid  out  ISSUE_WIDTH  assembled commit valid.
- commit_out_data  out  ISSUE_WIDTH x COMMIT_DATAW  {uuid, wid, tmask[NUM_THREADS], PC, wb, rd, data[NUM_THREADS][XLEN]}.
- commit_out_ready  in  ISSUE_WIDTH  downstream ready.

Behaviour:
- Slot selection: isw = wid mod ISSUE_WIDTH; the slot is combinational from pkt_in_data.
- Per slot there is one accumulator (tmask, data, header) plus one output register.
- Accumulator states:
  - IDLE -> COLLECT on an accepted sop && !eop packet.
  - COLLECT -> IDLE on an accepted eop packet.
  - IDLE -> IDLE on a packet with sop && eop.
- On sop: header {uuid, wid, PC, wb, rd} is captured. tmask bits and data lanes outside packet pid are cleared to 0.
- Every accepted packet writes tmask/data lanes [pid*NUM_LANES +: NUM_LANES]. Header fields of non-sop packets are ignored.
- eop acceptance transfers the accumulator merged with the current packet into the output register.
- Output timing:
  - With OUT_REG=1, commit_out_valid rises the cycle after eop acceptance.
  - With OUT_REG=0, it is valid in the same cycle and ready passes through.
- pkt_in_ready:
  - Non-eop packets: always 1.
  - eop packet: 1 iff the slot's output register is empty or commit_out_ready is 1 that cycle (drain and refill in the same cycle, full throughput).
- NUM_PACKETS=1: accumulator is bypassed. Block degenerates to a per-slot demux plus register, latency 1 (OUT_REG=1).
- Output is held stable while valid && !ready.
- Packets whose pid is absent (all-zero tmask in that packet) are never sent by dispatch. The gather unit does not require contiguous pids; it relies only on sop/eop.
- Error conditions, caught by simulation assertions (not handled in RTL):
  - sop received while in COLLECT.
  - non-sop received in IDLE.
  - wid change mid-COLLECT.
- Reset (reset==0 at a clk edge):
  - All commit_out_valid = 0.
  - All accumulators go to IDLE with tmask=0.
  - pkt_in_ready is forced to 0 while reset is asserted.
  - A partially collected packet is discarded.
- Width rules: pid is PID_WIDTH = UP(CLOG2(NUM_PACKETS)) bits; lane offset pid*NUM_LANES is computed at width CLOG2(NUM_THREADS)+1.

Optional Feature:
- Macro: COMMIT_GATHER_PERF_EN.
- When defined:
  - Adds output port perf_stall_cycles, ISSUE_WIDTH x 32: per-slot count of cycles with commit_out_valid && !commit_out_ready.
  - Adds output port perf_packets, 32 bits: count of accepted packets across all inputs.
  - Counters reset to 0 and wrap modulo 2^32.
- When undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared package (gpu package) holds:
  - PKT_DATAW, COMMIT_DATAW, PID_WIDTH.
  - Packed struct types pkt_data_t and commit_data_t.
  - Helper function wid_to_isw().
- Sub-module commit_gather_slot: one accumulator plus output register plus FSM per issue slot. The top level instantiates ISSUE_WIDTH of them and a demux per block input.

Test Plan (NUM_THREADS=4, NUM_LANES=2, ISSUE_WIDTH=2, BLOCK_SIZE=1, OUT_REG=1, XLEN=32):
- Full split: wid=1, pid0 sop (tmask 2'b11, data A,B), then pid1 eop (2'b11, C,D), ready=1 -> slot1 valid one cycle after eop, tmask 4'b1111, data {D,C,B,A}; slot0 valid stays 0.
- Sparse warp: single packet pid=1, sop=eop=1, tmask 2'b10, data X -> slot output tmask 4'b1000, data lane3=X, lanes0-2=0, latency 1.
- Backpressure: slot0 output valid with commit_out_ready=0; next warp's pid0 packet accepted; its eop packet sees pkt_in_ready=0 until ready=1 -> then output swaps in the same cycle with no bubble.
- Interleave: wid=0 and wid=1 packets alternate pid0/pid0/pid1/pid1 -> two correct independent outputs, slot0 then slot1.
- Reset mid-collect: pid0 of wid=0 accepted, reset=0 for one cycle, then full wid=0 packet pair -> only one output, tmask from the second sequence; no stale lanes.
- Perf (COMMIT_GATHER_PERF_EN): 3 stall cycles on slot1, 4 packets accepted -> perf_stall_cycles[1]=3, perf_packets=4.
